// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared encodings for the pipeline hazard controller
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  // R15 reads return the PC, never a forwarded result
  localparam logic [3:0] PC_REG = 4'd15;

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - priority comparator picking one operand's forwarding source
module fwd_select
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 4
) (
  input  logic [REG_W-1:0] src,
  input  logic             use_src,
  input  logic             ex_vld,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_load,
  input  logic             mem_vld,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             wb_vld,
  input  logic [REG_W-1:0] wb_rd,
  output logic [1:0]       fwd,
  output logic             ex_load_hit
);

  logic live;

  assign live = use_src && (src != REG_W'(PC_REG));

  // Youngest producer wins; a load still in EX has no data yet, so it
  // blocks older matches and reports a hit for the stall logic instead
  always_comb begin
    fwd         = FWD_RF;
    ex_load_hit = 1'b0;
    if (live && ex_vld && (ex_rd == src)) begin
      if (ex_load) ex_load_hit = 1'b1;
      else         fwd         = FWD_EX;
    end else if (live && mem_vld && (mem_rd == src)) begin
      fwd = FWD_MEM;
    end else if (live && wb_vld && (wb_rd == src)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall, flush, halt and forwarding control for the 5-stage pipe
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_use_rd,
  input  logic             id_rf_enable,
  input  logic             id_load,
  input  logic             id_b_instr,
  input  logic             id_cond_true,
  input  logic             halt,
  output logic             pc_le,
  output logic             ifid_e,
  output logic             ifid_clr,
  output logic             nop_sel,
  output logic             pc_sel_target,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       fwd_d,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state_o
);

  state_t state, state_nx;

  logic             ex_vld, ex_load, mem_vld, wb_vld;
  logic [REG_W-1:0] ex_rd, mem_rd, wb_rd;

  logic [1:0] sel_a, sel_b, sel_d;
  logic       hit_a, hit_b, hit_d;
  logic       load_use, br_taken;
  logic       stall_inc, flush_inc;

  fwd_select #(.REG_W(REG_W)) u_fwd_a (
    .src(id_rn), .use_src(id_use_rn),
    .ex_vld(ex_vld), .ex_rd(ex_rd), .ex_load(ex_load),
    .mem_vld(mem_vld), .mem_rd(mem_rd), .wb_vld(wb_vld), .wb_rd(wb_rd),
    .fwd(sel_a), .ex_load_hit(hit_a)
  );

  fwd_select #(.REG_W(REG_W)) u_fwd_b (
    .src(id_rm), .use_src(id_use_rm),
    .ex_vld(ex_vld), .ex_rd(ex_rd), .ex_load(ex_load),
    .mem_vld(mem_vld), .mem_rd(mem_rd), .wb_vld(wb_vld), .wb_rd(wb_rd),
    .fwd(sel_b), .ex_load_hit(hit_b)
  );

  fwd_select #(.REG_W(REG_W)) u_fwd_d (
    .src(id_rd), .use_src(id_use_rd),
    .ex_vld(ex_vld), .ex_rd(ex_rd), .ex_load(ex_load),
    .mem_vld(mem_vld), .mem_rd(mem_rd), .wb_vld(wb_vld), .wb_rd(wb_rd),
    .fwd(sel_d), .ex_load_hit(hit_d)
  );

  assign load_use = hit_a | hit_b | hit_d;
  assign br_taken = id_b_instr & id_cond_true;

  // While reset is held no stale scoreboard entry may steer the operand muxes
  assign fwd_a   = Clr ? sel_a : FWD_RF;
  assign fwd_b   = Clr ? sel_b : FWD_RF;
  assign fwd_d   = Clr ? sel_d : FWD_RF;
  assign state_o = state;

  // Scoreboard shift: a bubbled ID stage enters EX as an invalid entry
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      ex_vld  <= 1'b0;
      ex_rd   <= '0;
      ex_load <= 1'b0;
      mem_vld <= 1'b0;
      mem_rd  <= '0;
      wb_vld  <= 1'b0;
      wb_rd   <= '0;
    end else begin
      ex_vld  <= id_rf_enable & ~nop_sel;
      ex_rd   <= id_rd;
      ex_load <= id_load & ~nop_sel;
      mem_vld <= ex_vld;
      mem_rd  <= ex_rd;
      wb_vld  <= mem_vld;
      wb_rd   <= mem_rd;
    end
  end

  // FSM state register
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) state <= RUN;
    else      state <= state_nx;
  end

  // Next state and Mealy pipeline controls; halt > load-use > taken branch
  always_comb begin
    state_nx      = state;
    pc_le         = 1'b0;
    ifid_e        = 1'b0;
    ifid_clr      = 1'b0;
    nop_sel       = 1'b1;
    pc_sel_target = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    case (state)
      RUN, STALL: begin
        if (halt) begin
          state_nx = HALTED;
        end else if (load_use) begin
          // EX is a bubble during STALL, so a stall never repeats back to back
          state_nx  = (state == RUN) ? STALL : RUN;
          stall_inc = 1'b1;
        end else begin
          state_nx = RUN;
          pc_le    = 1'b1;
          ifid_e   = 1'b1;
          nop_sel  = 1'b0;
          if (br_taken) begin
            pc_sel_target = 1'b1;
            ifid_clr      = 1'b1;
            flush_inc     = 1'b1;
          end
        end
      end
      HALTED: begin
        if (!halt) state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
    if (!Clr) begin
      pc_le         = 1'b0;
      ifid_e        = 1'b0;
      ifid_clr      = 1'b1;
      nop_sel       = 1'b1;
      pc_sel_target = 1'b0;
    end
  end

  // Saturating performance counters
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed vector bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic        Clk, Clr;
  logic [3:0]  id_rn, id_rm, id_rd;
  logic        id_use_rn, id_use_rm, id_use_rd, id_rf_enable, id_load;
  logic        id_b_instr, id_cond_true, halt;
  logic        pc_le, ifid_e, ifid_clr, nop_sel, pc_sel_target;
  logic [1:0]  fwd_a, fwd_b, fwd_d, state_o;
  logic [15:0] stall_cnt, flush_cnt;

  logic [4:0] ctl_w;
  logic [5:0] fwd_w;
  assign ctl_w = {pc_le, ifid_e, ifid_clr, nop_sel, pc_sel_target};
  assign fwd_w = {fwd_a, fwd_b, fwd_d};

  localparam logic [4:0] RUNOK  = 5'b11000;
  localparam logic [4:0] STALLC = 5'b00010;
  localparam logic [4:0] HALTC  = 5'b00010;
  localparam logic [4:0] FLUSH  = 5'b11101;
  localparam logic [4:0] RSTC   = 5'b00110;

  pipeline_hazard_ctrl dut (
    .Clk(Clk), .Clr(Clr),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
    .id_rf_enable(id_rf_enable), .id_load(id_load),
    .id_b_instr(id_b_instr), .id_cond_true(id_cond_true), .halt(halt),
    .pc_le(pc_le), .ifid_e(ifid_e), .ifid_clr(ifid_clr), .nop_sel(nop_sel),
    .pc_sel_target(pc_sel_target),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_d(fwd_d),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state_o(state_o)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // flg = {use_rn, use_rm, use_rd, rf_enable, load, b_instr, cond_true, halt}
  typedef struct {
    logic [3:0]  rn, rm, rd;
    logic [7:0]  flg;
    logic [4:0]  ctl;
    logic [5:0]  fwd;
    logic [15:0] sc, fc;
    logic [1:0]  st;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs[NV];

  int n_total = 0;
  int n_pass  = 0;

  function automatic vec_t mk(input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rd,
                              input logic [7:0] flg, input logic [4:0] ctl, input logic [5:0] fwd,
                              input logic [15:0] sc, input logic [15:0] fc, input logic [1:0] st);
    vec_t v;
    v.rn = rn; v.rm = rm; v.rd = rd; v.flg = flg;
    v.ctl = ctl; v.fwd = fwd; v.sc = sc; v.fc = fc; v.st = st;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input vec_t v);
    id_rn = v.rn; id_rm = v.rm; id_rd = v.rd;
    {id_use_rn, id_use_rm, id_use_rd, id_rf_enable, id_load, id_b_instr, id_cond_true, halt} = v.flg;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    chk({tag, " ctl"},   {27'd0, ctl_w},     {27'd0, v.ctl});
    chk({tag, " fwd"},   {26'd0, fwd_w},     {26'd0, v.fwd});
    chk({tag, " cnt"},   {stall_cnt, flush_cnt}, {v.sc, v.fc});
    chk({tag, " state"}, {30'd0, state_o},   {30'd0, v.st});
  endtask

  initial begin
    vecs[0]  = mk(4'd2,  4'd3,  4'd1,  8'b11010000, RUNOK,  6'b000000, 16'd0, 16'd0, 2'd0); // ADD R1,R2,R3
    vecs[1]  = mk(4'd1,  4'd1,  4'd4,  8'b11010000, RUNOK,  6'b010100, 16'd0, 16'd0, 2'd0); // SUB R4,R1,R1
    vecs[2]  = mk(4'd1,  4'd0,  4'd7,  8'b11010000, RUNOK,  6'b100000, 16'd0, 16'd0, 2'd0); // R1 from MEM
    vecs[3]  = mk(4'd8,  4'd0,  4'd1,  8'b10100000, RUNOK,  6'b000011, 16'd0, 16'd0, 2'd0); // STR R1 from WB
    vecs[4]  = mk(4'd9,  4'd0,  4'd5,  8'b10011000, RUNOK,  6'b000000, 16'd0, 16'd0, 2'd0); // LDR R5
    vecs[5]  = mk(4'd5,  4'd0,  4'd6,  8'b11010000, STALLC, 6'b000000, 16'd0, 16'd0, 2'd0); // ADD R6,R5,R0
    vecs[6]  = mk(4'd5,  4'd0,  4'd6,  8'b11010000, RUNOK,  6'b100000, 16'd1, 16'd0, 2'd1); // re-presented
    vecs[7]  = mk(4'd0,  4'd0,  4'd0,  8'b00000110, FLUSH,  6'b000000, 16'd1, 16'd0, 2'd0); // B taken
    vecs[8]  = mk(4'd0,  4'd0,  4'd0,  8'b00000100, RUNOK,  6'b000000, 16'd1, 16'd1, 2'd0); // B not taken
    vecs[9]  = mk(4'd10, 4'd0,  4'd2,  8'b10011000, RUNOK,  6'b000000, 16'd1, 16'd1, 2'd0); // LDR R2
    vecs[10] = mk(4'd2,  4'd0,  4'd0,  8'b10000111, HALTC,  6'b000000, 16'd1, 16'd1, 2'd0); // BEQ + halt
    vecs[11] = mk(4'd2,  4'd0,  4'd0,  8'b10000111, HALTC,  6'b100000, 16'd1, 16'd1, 2'd2);
    vecs[12] = mk(4'd2,  4'd0,  4'd0,  8'b10000110, HALTC,  6'b110000, 16'd1, 16'd1, 2'd2); // halt drops
    vecs[13] = mk(4'd2,  4'd0,  4'd0,  8'b10000110, FLUSH,  6'b000000, 16'd1, 16'd1, 2'd0); // branch now
    vecs[14] = mk(4'd3,  4'd0,  4'd15, 8'b10011000, RUNOK,  6'b000000, 16'd1, 16'd2, 2'd0); // LDR R15
    vecs[15] = mk(4'd15, 4'd15, 4'd15, 8'b11100000, RUNOK,  6'b000000, 16'd1, 16'd2, 2'd0); // R15 reader
    vecs[16] = mk(4'd11, 4'd0,  4'd3,  8'b10011000, RUNOK,  6'b000000, 16'd1, 16'd2, 2'd0); // LDR R3
    vecs[17] = mk(4'd3,  4'd12, 4'd0,  8'b01000000, RUNOK,  6'b000000, 16'd1, 16'd2, 2'd0); // R3 unused
    vecs[18] = mk(4'd13, 4'd0,  4'd4,  8'b10011000, RUNOK,  6'b000000, 16'd1, 16'd2, 2'd0); // LDR R4
    vecs[19] = mk(4'd4,  4'd0,  4'd0,  8'b10000110, STALLC, 6'b000000, 16'd1, 16'd2, 2'd0); // B reads R4
    vecs[20] = mk(4'd4,  4'd0,  4'd0,  8'b10000110, FLUSH,  6'b100000, 16'd2, 16'd2, 2'd1);
    vecs[21] = mk(4'd0,  4'd0,  4'd0,  8'b00000000, RUNOK,  6'b000000, 16'd2, 16'd3, 2'd0);
    vecs[22] = mk(4'd0,  4'd0,  4'd8,  8'b00010000, RUNOK,  6'b000000, 16'd2, 16'd3, 2'd0); // write R8
    vecs[23] = mk(4'd8,  4'd0,  4'd8,  8'b10010000, RUNOK,  6'b010000, 16'd2, 16'd3, 2'd0); // write R8 again
    vecs[24] = mk(4'd8,  4'd0,  4'd0,  8'b10000000, RUNOK,  6'b010000, 16'd2, 16'd3, 2'd0); // EX beats MEM

    Clr = 1'b0;
    drive(mk(4'd0, 4'd0, 4'd0, 8'd0, RUNOK, 6'd0, 16'd0, 16'd0, 2'd0));
    @(negedge Clk);
    @(negedge Clk);
    chk("reset ctl", {27'd0, ctl_w}, {27'd0, RSTC});
    chk("reset fwd", {26'd0, fwd_w}, 32'd0);
    chk("reset cnt", {stall_cnt, flush_cnt}, 32'd0);
    chk("reset state", {30'd0, state_o}, 32'd0);
    Clr = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge Clk);
      #1 drive(vecs[i]);
      @(negedge Clk);
      check_vec($sformatf("v%0d", i), vecs[i]);
    end

    // Reset pulsed in the middle of a load-use stall
    @(posedge Clk);
    #1 drive(mk(4'd9, 4'd0, 4'd5, 8'b10011000, RUNOK, 6'd0, 16'd0, 16'd0, 2'd0));
    @(posedge Clk);
    #1 drive(mk(4'd5, 4'd0, 4'd6, 8'b11010000, RUNOK, 6'd0, 16'd0, 16'd0, 2'd0));
    @(negedge Clk);
    chk("mid ctl stall", {27'd0, ctl_w}, {27'd0, STALLC});
    @(posedge Clk);
    #2;
    chk("mid state stall", {30'd0, state_o}, 32'd1);
    Clr = 1'b0;
    #1;
    chk("mid rst state", {30'd0, state_o}, 32'd0);
    chk("mid rst cnt", {stall_cnt, flush_cnt}, 32'd0);
    chk("mid rst ctl", {27'd0, ctl_w}, {27'd0, RSTC});
    chk("mid rst fwd", {26'd0, fwd_w}, 32'd0);
    @(negedge Clk);
    Clr = 1'b1;
    @(posedge Clk);
    #1;
    @(negedge Clk);
    chk("post rst ctl", {27'd0, ctl_w}, {27'd0, RUNOK});
    chk("post rst fwd", {26'd0, fwd_w}, 32'd0);
    chk("post rst state", {30'd0, state_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
